// File: rtl/idex_pkg.sv
// idex_pkg: shared types and constants for the ID/EX pipeline stage
//   CTRL_W      - width of the packed control bundle
//   ctrl_t      - {r15, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch}
//   state_t     - occupancy state of the stage
//   CTRL_BUBBLE - control value carried by an empty (bubble) stage
package idex_pkg;

    localparam int CTRL_W = 7;

    typedef struct packed {
        logic r15;
        logic alu_src;
        logic mem_to_reg;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/idex_pipe_stage_if.sv
// idex_pipe_stage_if: ID->EX beat bus with flush, valid/ready on both sides
//   flush             - squash stage contents and incoming beat
//   in_valid/in_ready - ID-side handshake, in_* carry the decoded beat
//   out_valid/out_ready - EX-side handshake, out_* carry the main entry
//   modport master    - environment driving the stage (ID + EX view)
//   modport slave     - the pipeline stage itself
interface idex_pipe_stage_if import idex_pkg::*; #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int FUNCT_W    = 4,
    parameter int ALUOP_W    = 2
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_rd1;
    logic [DATA_W-1:0]     in_rd2;
    logic [DATA_W-1:0]     in_imm;
    logic [FUNCT_W-1:0]    in_funct;
    logic [REG_ADDR_W-1:0] in_rs;
    logic [REG_ADDR_W-1:0] in_rt;
    ctrl_t                 in_ctrl;
    logic [ALUOP_W-1:0]    in_alu_op;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_W-1:0]     out_rd1;
    logic [DATA_W-1:0]     out_rd2;
    logic [DATA_W-1:0]     out_imm;
    logic [FUNCT_W-1:0]    out_funct;
    logic [REG_ADDR_W-1:0] out_rs;
    logic [REG_ADDR_W-1:0] out_rt;
    ctrl_t                 out_ctrl;
    logic [ALUOP_W-1:0]    out_alu_op;

    modport master (
        output flush, in_valid, in_rd1, in_rd2, in_imm, in_funct, in_rs, in_rt, in_ctrl, in_alu_op, out_ready,
        input  in_ready, out_valid, out_rd1, out_rd2, out_imm, out_funct, out_rs, out_rt, out_ctrl, out_alu_op
    );

    modport slave (
        input  flush, in_valid, in_rd1, in_rd2, in_imm, in_funct, in_rs, in_rt, in_ctrl, in_alu_op, out_ready,
        output in_ready, out_valid, out_rd1, out_rd2, out_imm, out_funct, out_rs, out_rt, out_ctrl, out_alu_op
    );

endinterface

// File: rtl/idex_entry_reg.sv
// idex_entry_reg: one pipeline entry (data, control, valid)
//   clk, rst       - clock, async active-high reset (everything to zero)
//   i_load         - capture i_data/i_ctrl and set valid
//   i_clear        - drop valid and zero control; data is kept (wins over load)
//   o_valid/o_data/o_ctrl - registered entry contents
module idex_entry_reg #(
    parameter int DW = 1,
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_clear,
    input  logic [DW-1:0] i_data,
    input  logic [CW-1:0] i_ctrl,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_ctrl
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ctrl  <= '0;
        end else if (i_clear) begin
            o_valid <= 1'b0;
            o_ctrl  <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_ctrl  <= i_ctrl;
        end
    end

endmodule

// File: rtl/idex_pipe_stage.sv
// idex_pipe_stage: ID/EX stage register with 2-entry skid buffer and flush-to-bubble
//   clk, rst   - clock, async active-high reset
//   bus        - idex_pipe_stage_if.slave: flush, in_* (from ID), out_* (to EX)
//   stall_cnt, flush_cnt - saturating perf counters, only with IDEX_PERF_CNT_EN
module idex_pipe_stage import idex_pkg::*; #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4,
    parameter int FUNCT_W    = 4,
    parameter int ALUOP_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    idex_pipe_stage_if.slave    bus
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [15:0]         stall_cnt,
    output logic [15:0]         flush_cnt
`endif
);

    localparam int DW = 3 * DATA_W + FUNCT_W + 2 * REG_ADDR_W;
    localparam int CW = CTRL_W + ALUOP_W;

    state_t          r_state, w_next;
    logic            w_in_fire, w_out_fire;
    logic            w_main_load, w_main_clr, w_skid_load, w_skid_clr, w_from_skid;
    logic            w_main_valid, w_skid_valid;
    logic [DW-1:0]   w_in_data, w_main_data, w_skid_data, w_main_d;
    logic [CW-1:0]   w_in_ctrl, w_main_ctrl, w_skid_ctrl, w_main_c;

    assign w_in_data  = {bus.in_rd1, bus.in_rd2, bus.in_imm, bus.in_funct, bus.in_rs, bus.in_rt};
    assign w_in_ctrl  = {bus.in_ctrl, bus.in_alu_op};
    // in_ready is the registered complement of the skid valid bit, so no comb path from out_ready
    assign w_in_fire  = bus.in_valid & !w_skid_valid;
    assign w_out_fire = w_main_valid & bus.out_ready;
    assign w_main_d   = w_from_skid ? w_skid_data : w_in_data;
    assign w_main_c   = w_from_skid ? w_skid_ctrl : w_in_ctrl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_EMPTY;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_main_load = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        w_from_skid = 1'b0;
        if (bus.flush) begin
            w_next     = ST_EMPTY;
            w_main_clr = 1'b1;
            w_skid_clr = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    w_main_load = w_in_fire;
                    w_next      = w_in_fire ? ST_FULL : ST_EMPTY;
                end
                ST_FULL: begin
                    w_main_load = w_in_fire & w_out_fire;
                    w_skid_load = w_in_fire & !w_out_fire;
                    w_main_clr  = !w_in_fire & w_out_fire;
                    w_next      = w_skid_load ? ST_SKID : (w_main_clr ? ST_EMPTY : ST_FULL);
                end
                ST_SKID: begin
                    w_main_load = w_out_fire;
                    w_from_skid = 1'b1;
                    w_skid_clr  = w_out_fire;
                    w_next      = w_out_fire ? ST_FULL : ST_SKID;
                end
                default: w_next = ST_EMPTY;
            endcase
        end
    end

    idex_entry_reg #(.DW(DW), .CW(CW)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clr),
        .i_data  (w_main_d),
        .i_ctrl  (w_main_c),
        .o_valid (w_main_valid),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

    idex_entry_reg #(.DW(DW), .CW(CW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clr),
        .i_data  (w_in_data),
        .i_ctrl  (w_in_ctrl),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );

    assign bus.in_ready  = !w_skid_valid;
    assign bus.out_valid = w_main_valid;
    assign {bus.out_rd1, bus.out_rd2, bus.out_imm, bus.out_funct, bus.out_rs, bus.out_rt} = w_main_data;
    assign {bus.out_ctrl, bus.out_alu_op} = w_main_ctrl;

`ifdef IDEX_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (w_main_valid && !bus.out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
            // skid can only be valid when main is, so main valid means "non-empty"
            if (bus.flush && w_main_valid && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_idex_pipe_stage.sv
// tb_idex_pipe_stage: self-checking bench for idex_pipe_stage with a beat scoreboard
module tb_idex_pipe_stage;
    import idex_pkg::*;

    typedef struct packed {
        logic [15:0] rd1;
        logic [15:0] rd2;
        logic [15:0] imm;
        logic [3:0]  funct;
        logic [3:0]  rs;
        logic [3:0]  rt;
        ctrl_t       ctrl;
        logic [1:0]  alu_op;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    beat_t q[$];

    idex_pipe_stage_if bus ();

`ifdef IDEX_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    idex_pipe_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef IDEX_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    function automatic beat_t observe();
        beat_t o;
        o.rd1 = bus.out_rd1; o.rd2 = bus.out_rd2; o.imm = bus.out_imm;
        o.funct = bus.out_funct; o.rs = bus.out_rs; o.rt = bus.out_rt;
        o.ctrl = bus.out_ctrl; o.alu_op = bus.out_alu_op;
        return o;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b = {$urandom, $urandom, $urandom};
        b.ctrl.r15 = 1'b1;
        b.alu_op[0] = 1'b1;
        return b;
    endfunction

    task automatic drive(input beat_t b);
        bus.in_rd1 = b.rd1; bus.in_rd2 = b.rd2; bus.in_imm = b.imm;
        bus.in_funct = b.funct; bus.in_rs = b.rs; bus.in_rt = b.rt;
        bus.in_ctrl = b.ctrl; bus.in_alu_op = b.alu_op;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: every EX-side transfer must match the oldest expected beat
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL out_beat: got unexpected beat %h, required no output", observe());
            end else begin
                beat_t e;
                e = q.pop_front();
                if (observe() !== e) begin
                    errors++;
                    $display("FAIL out_beat: got %h, required %h", observe(), e);
                end
            end
        end
    end

    task automatic test_reset();
        beat_t b;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_ctrl !== 7'd0 || bus.out_rd1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_init: got valid=%b ready=%b ctrl=%h rd1=%h, required 0 1 00 0000",
                     bus.out_valid, bus.in_ready, bus.out_ctrl, bus.out_rd1);
        end
        rst = 1'b0;
        tick();
        b = rnd_beat();
        bus.out_ready = 1'b0;
        drive(b);
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_load: got out_valid=%b, required 1", bus.out_valid);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_ctrl !== 7'd0 ||
            bus.out_alu_op !== 2'd0 || bus.out_rd1 !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: got valid=%b ready=%b ctrl=%h aluop=%h rd1=%h, required 0 1 00 0 0000",
                     bus.out_valid, bus.in_ready, bus.out_ctrl, bus.out_alu_op, bus.out_rd1);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        beat_t b;
        b.rd1 = 16'd3; b.rd2 = 16'd7; b.imm = 16'd8; b.rs = 4'd9; b.rt = 4'd4;
        b.funct = 4'd2; b.alu_op = 2'd3; b.ctrl = 7'b1011000;
        bus.out_ready = 1'b1;
        drive(b);
        bus.in_valid = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready: got %b, required 1", bus.in_ready);
        end
        q.push_back(b);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rd1 !== 16'd3 || bus.out_ctrl !== 7'b1011000 || bus.out_alu_op !== 2'd3) begin
            errors++;
            $display("FAIL single_out: got valid=%b rd1=%h ctrl=%b aluop=%h, required 1 0003 1011000 3",
                     bus.out_valid, bus.out_rd1, bus.out_ctrl, bus.out_alu_op);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 7'd0 || bus.out_alu_op !== 2'd0 || bus.out_rd1 !== 16'd3) begin
            errors++;
            $display("FAIL single_drain: got valid=%b ctrl=%h aluop=%h rd1=%h, required 0 00 0 0003",
                     bus.out_valid, bus.out_ctrl, bus.out_alu_op, bus.out_rd1);
        end
    endtask

    task automatic test_back_pressure();
        beat_t a, b;
        a = rnd_beat(); a.rd1 = 16'd1;
        b = rnd_beat(); b.rd1 = 16'd2;
        bus.out_ready = 1'b0;
        drive(a);
        bus.in_valid = 1'b1;
        q.push_back(a);
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_after_a: got %b, required 1", bus.in_ready);
        end
        drive(b);
        q.push_back(b);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_rd1 !== 16'd1) begin
            errors++;
            $display("FAIL bp_skid: got ready=%b valid=%b rd1=%h, required 0 1 0001",
                     bus.in_ready, bus.out_valid, bus.out_rd1);
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_rd1 !== 16'd1) begin
            errors++;
            $display("FAIL bp_hold: got ready=%b rd1=%h, required 0 0001", bus.in_ready, bus.out_rd1);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_rd1 !== 16'd2) begin
            errors++;
            $display("FAIL bp_unskid: got ready=%b valid=%b rd1=%h, required 1 1 0002",
                     bus.in_ready, bus.out_valid, bus.out_rd1);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got valid=%b pending=%0d, required 0 0", bus.out_valid, q.size());
        end
    endtask

    task automatic test_flush_skid();
        bus.out_ready = 1'b0;
        drive(rnd_beat());
        bus.in_valid = 1'b1;
        tick();
        drive(rnd_beat());
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fs_enter_skid: got in_ready=%b, required 0", bus.in_ready);
        end
        drive(rnd_beat());
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 7'd0 || bus.out_alu_op !== 2'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fs_bubble: got valid=%b ctrl=%h aluop=%h ready=%b, required 0 00 0 1",
                     bus.out_valid, bus.out_ctrl, bus.out_alu_op, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fs_no_resurrect: got out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_flush_full();
        beat_t d;
        d = rnd_beat();
        bus.out_ready = 1'b1;
        drive(d);
        bus.in_valid = 1'b1;
        q.push_back(d);
        tick();
        drive(rnd_beat());
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_ctrl !== 7'd0) begin
            errors++;
            $display("FAIL ff_empty: got valid=%b ready=%b ctrl=%h, required 0 1 00",
                     bus.out_valid, bus.in_ready, bus.out_ctrl);
        end
        repeat (2) tick();
        checks++;
        if (bus.out_valid !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL ff_dropped: got valid=%b pending=%0d, required 0 0", bus.out_valid, q.size());
        end
    endtask

    task automatic test_back_to_back();
        beat_t b;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = rnd_beat();
            drive(b);
            bus.in_valid = 1'b1;
            q.push_back(b);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stream: got ready=%b valid=%b, required 1 1", bus.in_ready, bus.out_valid);
        end
        repeat (2) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got pending=%0d, required 0", q.size());
        end
    endtask

    task automatic test_random_stream();
        beat_t b;
        int sent = 0;
        int cyc = 0;
        logic acc;
        b = rnd_beat();
        drive(b);
        while (sent < 200 && cyc < 5000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = $urandom_range(0, 1);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (acc) begin
                q.push_back(b);
                sent++;
                b = rnd_beat();
                drive(b);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        tick();
        checks++;
        if (sent != 200 || q.size() != 0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_stream: got sent=%0d pending=%0d valid=%b, required 200 0 0",
                     sent, q.size(), bus.out_valid);
        end
    endtask

`ifdef IDEX_PERF_CNT_EN
    task automatic test_counters();
        beat_t b;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        b = rnd_beat();
        bus.out_ready = 1'b0;
        drive(b);
        bus.in_valid = 1'b1;
        q.push_back(b);
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        b = rnd_beat();
        drive(b);
        bus.in_valid = 1'b1;
        q.push_back(b);
        tick();
        bus.in_valid = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
        checks++;
        if (stall_cnt !== 16'd5 || flush_cnt !== 16'd2) begin
            errors++;
            $display("FAIL cnt_basic: got stall=%0d flush=%0d, required 5 2", stall_cnt, flush_cnt);
        end
        b = rnd_beat();
        bus.out_ready = 1'b0;
        drive(b);
        bus.in_valid = 1'b1;
        q.push_back(b);
        tick();
        bus.in_valid = 1'b0;
        repeat (70000) tick();
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_saturate: got stall=%h, required ffff", stall_cnt);
        end
        bus.out_ready = 1'b1;
        repeat (2) tick();
    endtask
`endif

    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive('0);
        repeat (2) tick();
        test_reset();
        test_single();
        test_back_pressure();
        test_flush_skid();
        test_flush_full();
        test_back_to_back();
        test_random_stream();
`ifdef IDEX_PERF_CNT_EN
        test_counters();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
